// File: rtl/pulse_wave_gen.sv
// Programmable square-wave generator: 2^D steps per period, duty and amplitude latched per period.
// Optional period marker enabled by macro PULSE_WAVE_GEN_PERIOD_MARK_EN (period_start tied 0 otherwise).
module pulse_wave_gen #(
   parameter int unsigned resolution_bits = 8,
   parameter int unsigned counter_width   = 8,
   parameter int unsigned duty_bits       = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       enable,
   input  logic [counter_width-1:0]   frequency_control,
   input  logic [duty_bits-1:0]       duty_control,
   input  logic [resolution_bits-1:0] amplitude,
   output logic [resolution_bits-1:0] square_out,
   output logic                       period_start
);

   localparam int unsigned RW = resolution_bits;
   localparam int unsigned CW = counter_width;
   localparam int unsigned DW = duty_bits;

   localparam logic [RW-1:0] MID      = {1'b1, {(RW-1){1'b0}}};
   localparam logic [DW-1:0] STEP_MAX = '1;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [0:0]    state_q,    state_d;
   logic [CW-1:0] cnt_q,      cnt_d;
   logic [DW-1:0] step_q,     step_d;
   logic [CW-1:0] freq_lat_q, freq_lat_d;
   logic [DW-1:0] duty_lat_q, duty_lat_d;
   logic [RW-1:0] amp_lat_q,  amp_lat_d;
   logic [RW-1:0] square_q,   square_d;
   logic          load_c;
   logic          run_c;

   // Half the swing above or below mid-scale; amp >> 1 keeps both within range.
   function automatic logic [RW-1:0] level(input logic hi, input logic [RW-1:0] amp);
      logic [RW-1:0] half;
      half = amp >> 1;
      return hi ? (MID + half) : (MID - half);
   endfunction

   assign run_c = !reset && enable;

   // Next-state: idle/reset/disable all park the counters and track the inputs.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      step_d     = step_q;
      freq_lat_d = freq_lat_q;
      duty_lat_d = duty_lat_q;
      amp_lat_d  = amp_lat_q;
      load_c     = 1'b0;

      if (!run_c || state_q == ST_IDLE) begin
         state_d = run_c ? ST_RUN : ST_IDLE;
         cnt_d   = '0;
         step_d  = '0;
         load_c  = 1'b1;
      end else if (cnt_q == freq_lat_q) begin
         cnt_d  = '0;
         step_d = step_q + DW'(1);
         load_c = (step_q == STEP_MAX);
      end else begin
         cnt_d = cnt_q + CW'(1);
      end

      if (load_c) begin
         freq_lat_d = frequency_control;
         duty_lat_d = duty_control;
         amp_lat_d  = amplitude;
      end

      // Output uses next-state step and latches so it moves on the same edge as step.
      square_d = run_c ? level(step_d < duty_lat_d, amp_lat_d) : MID;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         step_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         step_q  <= step_d;
      end
      freq_lat_q <= freq_lat_d;
      duty_lat_q <= duty_lat_d;
      amp_lat_q  <= amp_lat_d;
      square_q   <= square_d;
   end

   assign square_out = square_q;

`ifdef PULSE_WAVE_GEN_PERIOD_MARK_EN
   logic period_start_q, period_start_d;

   // Marks the first clock of a period: idle exit or the last-step wrap edge.
   always_comb begin
      period_start_d = 1'b0;
      if (run_c && (state_q == ST_IDLE || (cnt_q == freq_lat_q && step_q == STEP_MAX)))
         period_start_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) period_start_q <= 1'b0;
      else       period_start_q <= period_start_d;
   end

   assign period_start = period_start_q;
`else
   assign period_start = 1'b0;
`endif

endmodule

// File: tb/tb_pulse_wave_gen.sv
// Directed bench for pulse_wave_gen at R=8, C=8, D=4; expectations hand-derived per scenario.
module tb_pulse_wave_gen;

`ifdef PULSE_WAVE_GEN_PERIOD_MARK_EN
   localparam bit MARK = 1'b1;
`else
   localparam bit MARK = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic [7:0] frequency_control;
   logic [3:0] duty_control;
   logic [7:0] amplitude;
   logic [7:0] square_out;
   logic       period_start;

   int n_checks = 0;
   int n_fail   = 0;

   pulse_wave_gen #(
      .resolution_bits(8),
      .counter_width(8),
      .duty_bits(4)
   ) dut (
      .clk(clk),
      .reset(reset),
      .enable(enable),
      .frequency_control(frequency_control),
      .duty_control(duty_control),
      .amplitude(amplitude),
      .square_out(square_out),
      .period_start(period_start)
   );

   always #5 clk = ~clk;

   // Advance one edge and settle before sampling.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic setup(input logic [7:0] f, input logic [3:0] d, input logic [7:0] a);
      frequency_control = f;
      duty_control      = d;
      amplitude         = a;
      reset  = 1'b1;
      enable = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      setup(8'd1, 4'd8, 8'd254);
      reset = 1'b1;
      tick();
      n_checks++;
      if (square_out !== 8'h80) begin
         n_fail++;
         $display("FAIL reset_square got %0d want 128", square_out);
      end
      n_checks++;
      if (period_start !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_pstart got %0b want 0", period_start);
      end
      reset = 1'b0;
   endtask

   // freq=1 duty=8 amp=254: 16 clocks at 255, 16 at 1.
   task automatic test_half_duty();
      logic [7:0] exp_sq;
      logic       exp_ps;
      setup(8'd1, 4'd8, 8'd254);
      for (int k = 0; k < 64; k++) begin
         tick();
         exp_sq = ((k % 32) < 16) ? 8'd255 : 8'd1;
         exp_ps = MARK && ((k % 32) == 0);
         n_checks++;
         if (square_out !== exp_sq || period_start !== exp_ps) begin
            n_fail++;
            $display("FAIL half_duty k=%0d got sq=%0d ps=%0b want sq=%0d ps=%0b",
                     k, square_out, period_start, exp_sq, exp_ps);
         end
      end
   endtask

   task automatic test_zero_duty();
      logic exp_ps;
      setup(8'd0, 4'd0, 8'd200);
      for (int k = 0; k < 33; k++) begin
         tick();
         exp_ps = MARK && ((k % 16) == 0);
         n_checks++;
         if (square_out !== 8'd28 || period_start !== exp_ps) begin
            n_fail++;
            $display("FAIL zero_duty k=%0d got sq=%0d ps=%0b want sq=28 ps=%0b",
                     k, square_out, period_start, exp_ps);
         end
      end
   endtask

   // freq=2 duty=15 amp=100: 45 clocks at 178, 3 at 78.
   task automatic test_max_duty();
      logic [7:0] exp_sq;
      logic       exp_ps;
      setup(8'd2, 4'd15, 8'd100);
      for (int k = 0; k < 96; k++) begin
         tick();
         exp_sq = ((k % 48) < 45) ? 8'd178 : 8'd78;
         exp_ps = MARK && ((k % 48) == 0);
         n_checks++;
         if (square_out !== exp_sq || period_start !== exp_ps) begin
            n_fail++;
            $display("FAIL max_duty k=%0d got sq=%0d ps=%0b want sq=%0d ps=%0b",
                     k, square_out, period_start, exp_sq, exp_ps);
         end
      end
   endtask

   task automatic test_amp_zero();
      logic exp_ps;
      setup(8'd0, 4'd8, 8'd0);
      for (int k = 0; k < 20; k++) begin
         tick();
         exp_ps = MARK && ((k % 16) == 0);
         n_checks++;
         if (square_out !== 8'd128 || period_start !== exp_ps) begin
            n_fail++;
            $display("FAIL amp_zero k=%0d got sq=%0d ps=%0b want sq=128 ps=%0b",
                     k, square_out, period_start, exp_ps);
         end
      end
   endtask

   // Inputs change at k=10; first period stays 32 clocks, next is 64 with 16 high.
   task automatic test_midperiod_change();
      logic [7:0] exp_sq;
      logic       exp_ps;
      int         j;
      setup(8'd1, 4'd8, 8'd254);
      for (int k = 0; k < 97; k++) begin
         tick();
         if (k < 32) begin
            exp_sq = (k < 16) ? 8'd255 : 8'd1;
            exp_ps = MARK && (k == 0);
         end else begin
            j = (k - 32) % 64;
            exp_sq = (j < 16) ? 8'd255 : 8'd1;
            exp_ps = MARK && (j == 0);
         end
         n_checks++;
         if (square_out !== exp_sq || period_start !== exp_ps) begin
            n_fail++;
            $display("FAIL midperiod k=%0d got sq=%0d ps=%0b want sq=%0d ps=%0b",
                     k, square_out, period_start, exp_sq, exp_ps);
         end
         if (k == 10) begin
            frequency_control = 8'd3;
            duty_control      = 4'd4;
         end
      end
   endtask

   task automatic test_enable_drop();
      logic [7:0] exp_sq;
      logic       exp_ps;
      setup(8'd1, 4'd8, 8'd254);
      for (int k = 0; k < 5; k++) tick();
      enable = 1'b0;
      for (int k = 0; k < 2; k++) begin
         tick();
         n_checks++;
         if (square_out !== 8'd128 || period_start !== 1'b0) begin
            n_fail++;
            $display("FAIL enable_drop k=%0d got sq=%0d ps=%0b want sq=128 ps=0",
                     k, square_out, period_start);
         end
      end
      frequency_control = 8'd0;
      duty_control      = 4'd4;
      amplitude         = 8'd100;
      enable            = 1'b1;
      for (int k = 0; k < 17; k++) begin
         tick();
         exp_sq = ((k % 16) < 4) ? 8'd178 : 8'd78;
         exp_ps = MARK && ((k % 16) == 0);
         n_checks++;
         if (square_out !== exp_sq || period_start !== exp_ps) begin
            n_fail++;
            $display("FAIL enable_restart k=%0d got sq=%0d ps=%0b want sq=%0d ps=%0b",
                     k, square_out, period_start, exp_sq, exp_ps);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] exp_sq;
      logic       exp_ps;
      setup(8'd1, 4'd8, 8'd254);
      for (int k = 0; k < 7; k++) tick();
      reset = 1'b1;
      for (int k = 0; k < 2; k++) begin
         tick();
         n_checks++;
         if (square_out !== 8'd128 || period_start !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid k=%0d got sq=%0d ps=%0b want sq=128 ps=0",
                     k, square_out, period_start);
         end
      end
      reset = 1'b0;
      for (int k = 0; k < 33; k++) begin
         tick();
         exp_sq = ((k % 32) < 16) ? 8'd255 : 8'd1;
         exp_ps = MARK && ((k % 32) == 0);
         n_checks++;
         if (square_out !== exp_sq || period_start !== exp_ps) begin
            n_fail++;
            $display("FAIL reset_restart k=%0d got sq=%0d ps=%0b want sq=%0d ps=%0b",
                     k, square_out, period_start, exp_sq, exp_ps);
         end
      end
   endtask

   initial begin
      reset             = 1'b1;
      enable            = 1'b0;
      frequency_control = '0;
      duty_control      = '0;
      amplitude         = '0;
      test_reset();
      test_half_duty();
      test_zero_duty();
      test_max_duty();
      test_amp_zero();
      test_midperiod_change();
      test_enable_drop();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pulse_wave_gen.md
PULSE_WAVE_GEN -- requirements
Module: pulse_wave_gen

Interface
REQ-001 SHALL have parameter resolution_bits, default 8, meaning the square_out and amplitude width R.
REQ-002 SHALL have parameter counter_width, default 8, meaning the frequency_control and step-divider width C.
REQ-003 SHALL have parameter duty_bits, default 4, meaning the duty_control width D; each period has 2^D steps.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, the synchronous active-high reset.
REQ-006 SHALL have port enable, input, 1, run when 1 and idle when 0.
REQ-007 SHALL have port frequency_control, input, C, the step length minus 1 in clocks.
REQ-008 SHALL have port duty_control, input, D, the number of high steps per period.
REQ-009 SHALL have port amplitude, input, R, the peak-to-peak swing.
REQ-010 SHALL have port square_out, output, R, the registered unsigned waveform sample.
REQ-011 SHALL have port period_start, output, 1, a registered one-cycle marker for the first clock of each period.

Function
REQ-012 SHALL define MID = 2^(R-1), HIGH = MID + (amp_lat >> 1) and LOW = MID - (amp_lat >> 1); both stay within 1..2^R-1 by construction, with no wrap.
REQ-013 SHALL hold the state: idle flag; cnt (C bits); step (D bits); and latched freq_lat, duty_lat, amp_lat.
REQ-014 SHALL, while idle, force square_out = MID, period_start = 0, cnt = 0 and step = 0, and load the latches from the inputs on every edge.
REQ-015 SHALL, on an edge in idle with enable = 1, clear idle, set cnt = 0 and step = 0, load the latches, set period_start = 1, and drive square_out to the step-0 level.
REQ-016 SHALL, when running, advance as follows: if cnt == freq_lat then cnt <= 0 and step <= step + 1 (modulo 2^D); otherwise cnt <= cnt + 1.
REQ-017 SHALL give a step length of freq_lat + 1 clocks and a period of (freq_lat + 1) * 2^D clocks; frequency_control = 0 gives a 1-clock step.
REQ-018 SHALL compute square_out from next-state values, so it changes on the same edge as step with zero added latency: HIGH if step < duty_lat, else LOW.
REQ-019 SHALL produce square_out = LOW for the whole period when duty_lat = 0, and HIGH for (2^D - 1) of 2^D steps when duty_lat = 2^D - 1.
REQ-020 SHALL, at the wrap edge (cnt == freq_lat and step == 2^D - 1), reload all three latches from the inputs and set period_start = 1 for the following cycle; period_start SHALL be 0 at all other times.
REQ-021 SHALL ignore input changes mid-period; new values take effect only at the next wrap or idle exit (glitch-free update).
REQ-022 SHALL, when enable = 0 is sampled while running, enter idle on that edge (REQ-014), abandoning the period.
REQ-023 SHALL treat amplitude = 0 as square_out = MID constantly while running; period_start still pulses.

Reset
REQ-024 SHALL, on an edge with reset = 1, set idle = 1, cnt = 0, step = 0, square_out = MID (8'h80 at R = 8) and period_start = 0, and load the latches from the inputs; reset overrides enable.
REQ-025 SHALL, when reset is deasserted with enable = 1, start at the first following edge per REQ-015; reset asserted mid-period SHALL abort the period with no residual state.

Configuration
REQ-026 SHALL, with macro PULSE_WAVE_GEN_PERIOD_MARK_EN defined, drive period_start per REQ-011/015/020.
REQ-027 SHALL, without PULSE_WAVE_GEN_PERIOD_MARK_EN, keep the period_start port but tie it to constant 0, and omit its register; square_out behaviour is identical.

Verification (R = 8, C = 8, D = 4)
REQ-028 SHALL cover: reset, then enable = 1, freq = 1, duty = 8, amp = 254 -> square_out = 255 for 16 clocks, then 1 for 16 clocks, with period 32; period_start high on clock 0 of each period.
REQ-029 SHALL cover: freq = 0, duty = 0, amp = 200 -> square_out constantly 28; period_start every 16 clocks.
REQ-030 SHALL cover: freq = 2, duty = 15, amp = 100 -> 45 clocks at 178, then 3 clocks at 78, repeating every 48.
REQ-031 SHALL cover: change freq 1->3 and duty 8->4 mid-period -> the current period completes unchanged (32 clocks); the next period is 64 clocks with 16 high.
REQ-032 SHALL cover: drop enable mid-step, then reassert -> square_out = 128 the edge after the drop; the restart yields step 0 with period_start = 1 and fresh latched values.
REQ-033 SHALL cover: assert reset mid-period with enable = 1 -> square_out = 128 and period_start = 0 the next edge; on release, a full period restarts; in a build without the macro, period_start stays 0 throughout.
